jtag_tap_oversampled: RTL and testbench
=======================================

Name: jtag_tap_oversampled

Overview:
- Clock-domain JTAG TAP responder: the target end of a JTAG link driven by a bit-banging host or simulation driver.
- Oversamples TCK/TMS/TDI/TRSTn in the clk_i domain and runs a full IEEE 1149.1 16-state TAP FSM.
- Provides IDCODE, BYPASS and one USER data register with a capture/update handshake to core logic.
- Used as a lightweight DTM front-end in testbenches and FPGA targets where TCK is slow relative to clk_i.

Parameters:
- IDCODE, 32'h1000_0001, value returned by the IDCODE DR; bit 0 must be 1.
- IR_LEN, 5, instruction register width; minimum 2.
- DR_W, 32, USER data register width; minimum 1.
- SYNC_STAGES, 2, synchronizer depth on all JTAG inputs; minimum 2.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- jtag_tck_i  in  1  raw TCK.
- jtag_tms_i  in  1  raw TMS.
- jtag_tdi_i  in  1  raw TDI.
- jtag_trst_ni  in  1  raw TRSTn, active low.
- jtag_tdo_o  out  1  TDO data.
- jtag_tdo_oe_o  out  1  TDO driven; high only in Shift-IR and Shift-DR.
- user_capture_o  out  1  one-clk pulse on USER Capture-DR.
- user_dr_i  in  DR_W  value captured into the USER shift register.
- user_update_o  out  1  one-clk pulse on USER Update-DR.
- user_dr_o  out  DR_W  USER register contents latched at Update-DR.
- ir_o  out  IR_LEN  current instruction.
- tap_state_o  out  4  FSM state encoding.

Behaviour:
- Reset: rst_ni low → FSM = Test-Logic-Reset, ir_o = IDCODE instruction, jtag_tdo_o = 0, jtag_tdo_oe_o = 0, user_dr_o = 0, user_capture_o = 0, user_update_o = 0, all synchronizers = 0.
- Synchronization: each input passes through SYNC_STAGES flops.
  - tck_rise / tck_fall are one-clk pulses from comparing the synced TCK with a delay flop.
  - Pin-to-action latency is SYNC_STAGES+1 clk.
  - TCK high and low phases must each last ≥ SYNC_STAGES+2 clk; shorter pulses are unsupported.
- Synced TRSTn low: FSM forced to TLR and IR forced to IDCODE. This is level-sensitive and overrides a simultaneous tck_rise.
- State encoding (4'h0–4'hF):
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
  - Transitions follow IEEE 1149.1 on synced TMS at tck_rise.
- Register actions execute on tck_rise according to the state held before that edge; the state update happens on the same edge:
  - CapIR: IR shift register ← {0…, 2'b01}.
  - ShIR: IR shift ← {tdi, sr[IR_LEN-1:1]}.
  - UpdIR: ir_o ← IR shift register.
  - CapDR: selected DR loaded. BYPASS ← 0, IDCODE ← IDCODE, USER ← user_dr_i, and user_capture_o pulses.
  - ShDR: selected DR shifts right, TDI entering at the MSB.
  - UpdDR with USER selected: user_dr_o ← shift register, and user_update_o pulses.
- TLR entered via TMS (5 consecutive TMS=1 from any state) sets ir_o = IDCODE.
- Instruction decode:
  - 5'h01 = IDCODE.
  - 5'h10 = USER.
  - 5'h1F = BYPASS.
  - All other codes select BYPASS (1-bit register).
- TDO: updated on tck_fall.
  - jtag_tdo_o ← LSB of the active shift register in ShIR/ShDR, else 0.
  - jtag_tdo_oe_o ← 1 in ShIR/ShDR, else 0.
- Pause states hold shift contents. Re-entering Shift resumes without reload.
- rst_ni assertion mid-scan discards partial shift data. user_dr_o returns to 0.

Optional Feature:
- Macro JTAG_TAP_USERCODE_EN.
- Defined:
  - Adds parameter USERCODE (default 32'h0000_0000).
  - Adds instruction 5'h02 selecting a 32-bit USERCODE DR that captures USERCODE at CapDR.
- Undefined:
  - No USERCODE parameter.
  - 5'h02 decodes to BYPASS.

Test Plan:
- Reset and IDCODE: deassert rst_ni, 5 TCK with TMS=1, go to ShDR, shift 32 bits → TDO yields 32'h1000_0001 LSB-first; tdo_oe high only during the shift.
- BYPASS: load IR=5'h1F, shift TDI pattern 1,0,1,1 in ShDR → TDO returns 0,1,0,1 (one-bit delay, leading 0).
- USER write: IR=5'h10, user_dr_i=32'hA5A5_0F0F, shift in 32'hDEAD_BEEF then UpdDR → TDO shows A5A50F0F, user_capture_o and user_update_o each pulse exactly 1 clk, user_dr_o=32'hDEAD_BEEF.
- IR capture/unknown opcode: ShIR shifting 5'h07 → TDO shows 5'b00001; ShDR then behaves as BYPASS.
- TRSTn mid-scan: pull jtag_trst_ni low while in ShDR → tap_state_o=4'hF within SYNC_STAGES+1 clk, ir_o=5'h01, tdo_oe=0 after the next tck_fall.
- Pause/resume: shift 16 bits, PauseDR for 10 TCK, Ex2DR→ShDR, shift 16 more → full 32-bit word correct at UpdDR.

Source files
------------

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP target whose TCK/TMS/TDI/TRSTn pins are oversampled in the clk_i domain, with IDCODE, BYPASS and USER DRs.
// Defining JTAG_TAP_USERCODE_EN adds a USERCODE DR on instruction 5'h02.
module jtag_tap_oversampled #(
   parameter logic [31:0] IDCODE      = 32'h1000_0001,
   parameter int          IR_LEN      = 5,
   parameter int          DR_W        = 32,
   parameter int          SYNC_STAGES = 2
`ifdef JTAG_TAP_USERCODE_EN
   ,
   parameter logic [31:0] USERCODE    = 32'h0000_0000
`endif
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              jtag_tck_i,
   input  logic              jtag_tms_i,
   input  logic              jtag_tdi_i,
   input  logic              jtag_trst_ni,
   output logic              jtag_tdo_o,
   output logic              jtag_tdo_oe_o,
   output logic              user_capture_o,
   input  logic [DR_W-1:0]   user_dr_i,
   output logic              user_update_o,
   output logic [DR_W-1:0]   user_dr_o,
   output logic [IR_LEN-1:0] ir_o,
   output logic [3:0]        tap_state_o
);

   typedef enum logic [3:0] {
      TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
      PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
      SH_IR = 4'hA, EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } tap_state_e;

   localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(5'h01);
   localparam logic [IR_LEN-1:0] IR_USER   = IR_LEN'(5'h10);

   // Pin order inside each synchronizer word: {trst_n, tdi, tms, tck}
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_d [SYNC_STAGES];

   for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
         assign sync_d[gi] = {jtag_trst_ni, jtag_tdi_i, jtag_tms_i, jtag_tck_i};
      end else begin : g_next
         assign sync_d[gi] = sync_q[gi-1];
      end
   end

   logic tck_s, tms_s, tdi_s, trst_s;
   assign {trst_s, tdi_s, tms_s, tck_s} = sync_q[SYNC_STAGES-1];

   logic tck_dly_q, tck_dly_d;
   logic tck_rise, tck_fall;
   assign tck_dly_d = tck_s;
   assign tck_rise  = tck_s & ~tck_dly_q;
   assign tck_fall  = ~tck_s & tck_dly_q;

   tap_state_e          state_q, state_d, tap_next;
   logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d, ir_q, ir_d;
   logic                bypass_q, bypass_d;
   logic [31:0]         idcode_sr_q, idcode_sr_d;
   logic [DR_W-1:0]     user_sr_q, user_sr_d, user_dr_q, user_dr_d;
   logic                cap_q, cap_d, upd_q, upd_d, tdo_q, tdo_d, oe_q, oe_d;
   logic                sel_user, sel_idcode, dr_lsb;

`ifdef JTAG_TAP_USERCODE_EN
   localparam logic [IR_LEN-1:0] IR_USERCODE = IR_LEN'(5'h02);
   logic [31:0] ucode_sr_q, ucode_sr_d;
   logic        sel_ucode;
   assign sel_ucode = (ir_q == IR_USERCODE);
`endif

   assign sel_user   = (ir_q == IR_USER);
   assign sel_idcode = (ir_q == IR_IDCODE);

   always_comb begin : fsm_next
      tap_next = state_q;
      case (state_q)
         TLR:      tap_next = tms_s ? TLR    : RTI;
         RTI:      tap_next = tms_s ? SEL_DR : RTI;
         SEL_DR:   tap_next = tms_s ? SEL_IR : CAP_DR;
         CAP_DR:   tap_next = tms_s ? EX1_DR : SH_DR;
         SH_DR:    tap_next = tms_s ? EX1_DR : SH_DR;
         EX1_DR:   tap_next = tms_s ? UPD_DR : PAUSE_DR;
         PAUSE_DR: tap_next = tms_s ? EX2_DR : PAUSE_DR;
         EX2_DR:   tap_next = tms_s ? UPD_DR : SH_DR;
         UPD_DR:   tap_next = tms_s ? SEL_DR : RTI;
         SEL_IR:   tap_next = tms_s ? TLR    : CAP_IR;
         CAP_IR:   tap_next = tms_s ? EX1_IR : SH_IR;
         SH_IR:    tap_next = tms_s ? EX1_IR : SH_IR;
         EX1_IR:   tap_next = tms_s ? UPD_IR : PAUSE_IR;
         PAUSE_IR: tap_next = tms_s ? EX2_IR : PAUSE_IR;
         EX2_IR:   tap_next = tms_s ? UPD_IR : SH_IR;
         UPD_IR:   tap_next = tms_s ? SEL_DR : RTI;
         default:  tap_next = TLR;
      endcase
      state_d = state_q;
      if (!trst_s) begin
         state_d = TLR;
      end else if (tck_rise) begin
         state_d = tap_next;
      end
   end

   always_comb begin : dr_lsb_mux
      dr_lsb = bypass_q;
      if (sel_user) begin
         dr_lsb = user_sr_q[0];
      end else if (sel_idcode) begin
         dr_lsb = idcode_sr_q[0];
      end
`ifdef JTAG_TAP_USERCODE_EN
      else if (sel_ucode) begin
         dr_lsb = ucode_sr_q[0];
      end
`endif
   end

   always_comb begin : datapath
      ir_sr_d     = ir_sr_q;
      ir_d        = ir_q;
      bypass_d    = bypass_q;
      idcode_sr_d = idcode_sr_q;
      user_sr_d   = user_sr_q;
      user_dr_d   = user_dr_q;
      cap_d       = 1'b0;
      upd_d       = 1'b0;
      tdo_d       = tdo_q;
      oe_d        = oe_q;
`ifdef JTAG_TAP_USERCODE_EN
      ucode_sr_d  = ucode_sr_q;
`endif
      if (tck_rise) begin
         case (state_q)
            CAP_IR: ir_sr_d = IR_LEN'(2'b01);
            SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_LEN-1:1]};
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
               bypass_d    = 1'b0;
               idcode_sr_d = IDCODE;
`ifdef JTAG_TAP_USERCODE_EN
               ucode_sr_d  = USERCODE;
`endif
               if (sel_user) begin
                  user_sr_d = user_dr_i;
                  cap_d     = 1'b1;
               end
            end
            SH_DR: begin
               // Shift through a DR_W+1 concatenation so a 1-bit USER DR needs no special case
               if (sel_user) begin
                  user_sr_d = DR_W'({tdi_s, user_sr_q} >> 1);
               end else if (sel_idcode) begin
                  idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
               end
`ifdef JTAG_TAP_USERCODE_EN
               else if (sel_ucode) begin
                  ucode_sr_d = {tdi_s, ucode_sr_q[31:1]};
               end
`endif
               else begin
                  bypass_d = tdi_s;
               end
            end
            UPD_DR: begin
               if (sel_user) begin
                  user_dr_d = user_sr_q;
                  upd_d     = 1'b1;
               end
            end
            default: ;
         endcase
         if (tap_next == TLR) begin
            ir_d = IR_IDCODE;
         end
      end
      if (tck_fall) begin
         tdo_d = 1'b0;
         oe_d  = 1'b0;
         if (state_q == SH_IR) begin
            tdo_d = ir_sr_q[0];
            oe_d  = 1'b1;
         end else if (state_q == SH_DR) begin
            tdo_d = dr_lsb;
            oe_d  = 1'b1;
         end
      end
      if (!trst_s) begin
         ir_d = IR_IDCODE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         tck_dly_q   <= 1'b0;
         state_q     <= TLR;
         ir_sr_q     <= '0;
         ir_q        <= IR_IDCODE;
         bypass_q    <= 1'b0;
         idcode_sr_q <= '0;
         user_sr_q   <= '0;
         user_dr_q   <= '0;
         cap_q       <= 1'b0;
         upd_q       <= 1'b0;
         tdo_q       <= 1'b0;
         oe_q        <= 1'b0;
`ifdef JTAG_TAP_USERCODE_EN
         ucode_sr_q  <= '0;
`endif
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         tck_dly_q   <= tck_dly_d;
         state_q     <= state_d;
         ir_sr_q     <= ir_sr_d;
         ir_q        <= ir_d;
         bypass_q    <= bypass_d;
         idcode_sr_q <= idcode_sr_d;
         user_sr_q   <= user_sr_d;
         user_dr_q   <= user_dr_d;
         cap_q       <= cap_d;
         upd_q       <= upd_d;
         tdo_q       <= tdo_d;
         oe_q        <= oe_d;
`ifdef JTAG_TAP_USERCODE_EN
         ucode_sr_q  <= ucode_sr_d;
`endif
      end
   end

   assign jtag_tdo_o     = tdo_q;
   assign jtag_tdo_oe_o  = oe_q;
   assign user_capture_o = cap_q;
   assign user_update_o  = upd_q;
   assign user_dr_o      = user_dr_q;
   assign ir_o           = ir_q;
   assign tap_state_o    = state_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Bench for jtag_tap_oversampled: bit-banged TCK driver, vector table of IR/DR scans and a scoreboard queue of expected results.
module tb_jtag_tap_oversampled;

   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst_n, tck, tms, tdi, trst_n;
   logic        tdo, tdo_oe, cap, upd;
   logic [31:0] udr_i, udr_o;
   logic [4:0]  ir;
   logic [3:0]  st;

   int checks = 0;
   int passes = 0;
   int oe_bad = 0;
   int cap_total = 0;
   int upd_total = 0;

   always #5 clk = ~clk;

   jtag_tap_oversampled dut (
      .clk_i(clk), .rst_ni(rst_n),
      .jtag_tck_i(tck), .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_trst_ni(trst_n),
      .jtag_tdo_o(tdo), .jtag_tdo_oe_o(tdo_oe),
      .user_capture_o(cap), .user_dr_i(udr_i), .user_update_o(upd), .user_dr_o(udr_o),
      .ir_o(ir), .tap_state_o(st)
   );

   // Number of clk cycles each pulse is high; one pulse of one clk adds exactly 1
   always @(posedge clk) begin
      if (cap) cap_total <= cap_total + 1;
      if (upd) upd_total <= upd_total + 1;
   end

   typedef struct {
      logic [4:0]  op;
      logic [31:0] udr;
      logic [31:0] din;
      int          n;
      logic [31:0] exp_tdo;
      logic [31:0] exp_udo;
      int          exp_pulse;
   } vec_t;

   typedef struct {
      logic [31:0] tdo;
      logic [31:0] udo;
      int          pulse;
      logic [4:0]  ir;
   } exp_t;

   vec_t vecs [6];
   exp_t sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One TCK period: falling edge with new TMS/TDI, sample TDO just before the rising edge
   task automatic tck_cycle(input logic tms_v, input logic tdi_v, input logic exp_oe, output logic tdo_v);
      tck = 1'b0;
      tms = tms_v;
      tdi = tdi_v;
      repeat (HALF) @(posedge clk);
      #1;
      tdo_v = tdo;
      if (tdo_oe !== exp_oe) oe_bad++;
      tck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic b;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         tck_cycle((i == n - 1), din[i], 1'b1, b);
         dout[i] = b;
      end
   endtask

   task automatic load_ir(input logic [4:0] op, output logic [4:0] irt);
      logic        b;
      logic [31:0] d;
      tck_cycle(1, 0, 0, b);
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      shift(5, {27'd0, op}, d);
      irt = d[4:0];
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
   endtask

   task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic b;
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      shift(n, din, dout);
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        b;
      logic [4:0]  irt;
      logic [31:0] dout, lo, hi;
      int          c0, u0;
      exp_t        e;

      vecs[0] = '{5'h01, 32'h0000_0000, 32'h0F0F_0F0F, 32, 32'h1000_0001, 32'h0000_0000, 0};
      vecs[1] = '{5'h1F, 32'h0000_0000, 32'h0000_000D,  4, 32'h0000_000A, 32'h0000_0000, 0};
      vecs[2] = '{5'h10, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 32, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 1};
      vecs[3] = '{5'h07, 32'h1111_1111, 32'h0000_00C3,  8, 32'h0000_0086, 32'hDEAD_BEEF, 0};
      vecs[4] = '{5'h02, 32'h2222_2222, 32'h0000_005A,  8, 32'h0000_00B4, 32'hDEAD_BEEF, 0};
      vecs[5] = '{5'h10, 32'h1234_5678, 32'h0000_FFFF, 32, 32'h1234_5678, 32'h0000_FFFF, 1};

      rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1; udr_i = '0;
      repeat (5) @(posedge clk);
      #1;
      check("reset_state", {28'd0, st}, 32'hF);
      check("reset_ir", {27'd0, ir}, 32'h01);
      check("reset_tdo", {31'd0, tdo}, 32'h0);
      check("reset_oe", {31'd0, tdo_oe}, 32'h0);
      check("reset_user_dr", udr_o, 32'h0);
      check("reset_capture", {31'd0, cap}, 32'h0);
      check("reset_update", {31'd0, upd}, 32'h0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) tck_cycle(1, 0, 0, b);
      check("tlr_after_tms", {28'd0, st}, 32'hF);
      tck_cycle(0, 0, 0, b);
      check("rti_entry", {28'd0, st}, 32'hC);

      for (int i = 0; i < 6; i++) begin
         udr_i = vecs[i].udr;
         sb.push_back('{vecs[i].exp_tdo, vecs[i].exp_udo, vecs[i].exp_pulse, vecs[i].op});
         c0 = cap_total;
         u0 = upd_total;
         oe_bad = 0;
         load_ir(vecs[i].op, irt);
         check("ir_capture_tdo", {27'd0, irt}, 32'h01);
         e = sb.pop_front();
         check("ir_update", {27'd0, ir}, {27'd0, e.ir});
         scan_dr(vecs[i].n, vecs[i].din, dout);
         repeat (3) @(posedge clk);
         #1;
         check("dr_tdo", dout, e.tdo);
         check("user_dr_o", udr_o, e.udo);
         check("capture_pulse", cap_total - c0, e.pulse);
         check("update_pulse", upd_total - u0, e.pulse);
         check("oe_window", oe_bad, 0);
         $display("vec %0d op=%h tdi=%h tdo=%h user_dr_o=%h", i, vecs[i].op, vecs[i].din, dout, udr_o);
      end

      load_ir(5'h10, irt);
      check("ir_user_before_tlr", {27'd0, ir}, 32'h10);
      for (int i = 0; i < 5; i++) tck_cycle(1, 0, 0, b);
      check("tms_tlr_state", {28'd0, st}, 32'hF);
      check("tms_tlr_ir", {27'd0, ir}, 32'h01);
      tck_cycle(0, 0, 0, b);
      $display("tlr via tms: state=%h ir=%h", st, ir);

      load_ir(5'h10, irt);
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      oe_bad = 0;
      for (int i = 0; i < 5; i++) tck_cycle(0, 1, 1, b);
      check("trst_pre_oe", oe_bad, 0);
      trst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("trst_state", {28'd0, st}, 32'hF);
      check("trst_ir", {27'd0, ir}, 32'h01);
      tck_cycle(0, 0, 0, b);
      check("trst_oe_after_fall", {31'd0, tdo_oe}, 32'h0);
      check("trst_holds_tlr", {28'd0, st}, 32'hF);
      trst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      tck_cycle(0, 0, 0, b);
      check("trst_release_rti", {28'd0, st}, 32'hC);
      $display("trst mid-scan: state=%h ir=%h oe=%b", st, ir, tdo_oe);

      udr_i = 32'h3C3C_C3C3;
      sb.push_back('{32'h3C3C_C3C3, 32'h1357_9BDF, 1, 5'h10});
      c0 = cap_total;
      u0 = upd_total;
      load_ir(5'h10, irt);
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      shift(16, 32'h0000_9BDF, lo);
      tck_cycle(0, 0, 0, b);
      for (int i = 0; i < 10; i++) tck_cycle(0, 0, 0, b);
      check("pause_state", {28'd0, st}, 32'h3);
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      shift(16, 32'h0000_1357, hi);
      tck_cycle(1, 0, 0, b);
      tck_cycle(0, 0, 0, b);
      repeat (3) @(posedge clk);
      #1;
      e = sb.pop_front();
      check("pause_tdo", {hi[15:0], lo[15:0]}, e.tdo);
      check("pause_user_dr_o", udr_o, e.udo);
      check("pause_capture", cap_total - c0, e.pulse);
      check("pause_update", upd_total - u0, e.pulse);
      $display("pause/resume: tdo=%h user_dr_o=%h", {hi[15:0], lo[15:0]}, udr_o);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
